// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice processes one operand bit
// per clock, LSB first, under a start/busy/done handshake.
module serial_addsub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] opA_q;
   logic [WIDTH-1:0] opB_q;
   logic [WIDTH-1:0] res_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;

   logic             sumBit_d;
   logic             carry_d;
   logic [WIDTH-1:0] res_d;
   logic             lastBit_d;

   // The full-adder slice and the result shifter; the new bit enters at the MSB
   // so that after WIDTH shifts the result is aligned with bit 0 at the LSB.
   always_comb begin
      sumBit_d  = opA_q[0] ^ opB_q[0] ^ carry_q;
      carry_d   = (opA_q[0] & opB_q[0]) | (opA_q[0] & carry_q) | (opB_q[0] & carry_q);
      res_d     = WIDTH'({sumBit_d, res_q} >> 1);
      lastBit_d = (cnt_q == CW'(WIDTH - 1));
   end

   // Subtraction is a + ~b + 1, so the operand inversion and forced carry are
   // applied once at load; the datapath itself only ever adds.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         opA_q   <= '0;
         opB_q   <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  opA_q   <= a;
                  opB_q   <= sub ? ~b : b;
                  carry_q <= sub ? 1'b1 : cin;
                  res_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            RUN: begin
               opA_q   <= opA_q >> 1;
               opB_q   <= opB_q >> 1;
               carry_q <= carry_d;
               res_q   <= res_d;
               cnt_q   <= cnt_q + CW'(1);
               // carry_q here is the carry into the MSB, needed for overflow.
               if (lastBit_d) begin
                  sum_q   <= res_d;
                  cout_q  <= carry_d;
                  ovf_q   <= carry_q ^ carry_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed table, handshake and reset
// sequences, random operations at WIDTH=8, exhaustive operations at WIDTH=2.
module tb_serial_addsub;

   logic       clk;
   logic       rst;
   logic       start, sub, cin;
   logic [7:0] a, b, sum;
   logic       busy, done, cout, overflow;

   logic       start2, sub2, cin2;
   logic [1:0] a2, b2, sum2;
   logic       busy2, done2, cout2, overflow2;

   int         total;
   int         bad;
   logic [7:0] lastSum;

   serial_addsub #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
   );

   serial_addsub #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2), .cin(cin2),
      .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .overflow(overflow2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   typedef struct {
      logic       sub;
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } vec_t;

   // Reference arithmetic on plain integers: unsigned result modulo 2^w,
   // carry/no-borrow from the unsigned range, overflow from the signed range.
   function automatic res_t model(input int w, input logic s, input longint av,
                                  input longint bv, input logic ci);
      res_t   r;
      longint m, sa, sb, full, sres;
      m  = longint'(1) << w;
      sa = (av >= m / 2) ? av - m : av;
      sb = (bv >= m / 2) ? bv - m : bv;
      if (s) begin
         full   = av - bv;
         r.sum  = 64'((full + m) % m);
         r.cout = (av >= bv);
         sres   = sa - sb;
      end else begin
         full   = av + bv + longint'(ci);
         r.sum  = 64'(full % m);
         r.cout = (full >= m);
         sres   = sa + sb + longint'(ci);
      end
      r.ovf = (sres < -(m / 2)) || (sres > (m / 2) - 1);
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Starts one WIDTH=8 operation in the current cycle and returns in its done cycle.
   task automatic applyStimulus(input logic s, input logic [7:0] av, input logic [7:0] bv,
                                input logic ci, output int lat, output logic busyOk,
                                output logic holdOk);
      sub   = s;
      a     = av;
      b     = bv;
      cin   = ci;
      start = 1'b1;
      step();
      start = 1'b0;
      sub   = 1'($urandom);
      a     = 8'($urandom);
      b     = 8'($urandom);
      cin   = 1'($urandom);
      lat    = 1;
      busyOk = 1'b1;
      holdOk = 1'b1;
      while (done !== 1'b1 && lat < 40) begin
         if (busy !== 1'b1) busyOk = 1'b0;
         if (sum !== lastSum) holdOk = 1'b0;
         step();
         lat++;
      end
      if (busy !== 1'b0) busyOk = 1'b0;
   endtask

   task automatic runAndCheck(input string tag, input logic s, input logic [7:0] av,
                              input logic [7:0] bv, input logic ci, input logic [7:0] expSum,
                              input logic expCout, input logic expOvf);
      int   lat;
      logic busyOk, holdOk;
      applyStimulus(s, av, bv, ci, lat, busyOk, holdOk);
      checkOutput({tag, " latency"}, 64'(lat), 64'd9);
      checkOutput({tag, " busy"}, 64'(busyOk), 64'd1);
      checkOutput({tag, " hold"}, 64'(holdOk), 64'd1);
      checkOutput({tag, " sum"}, 64'(sum), 64'(expSum));
      checkOutput({tag, " cout"}, 64'(cout), 64'(expCout));
      checkOutput({tag, " overflow"}, 64'(overflow), 64'(expOvf));
      lastSum = expSum;
   endtask

   task automatic applyStimulus2(input logic s, input logic [1:0] av, input logic [1:0] bv,
                                 input logic ci, output int lat);
      sub2   = s;
      a2     = av;
      b2     = bv;
      cin2   = ci;
      start2 = 1'b1;
      step();
      start2 = 1'b0;
      lat = 1;
      while (done2 !== 1'b1 && lat < 20) begin
         step();
         lat++;
      end
   endtask

   initial begin
      vec_t  vecs[7];
      res_t  r;
      int    lat;
      logic  busyOk, holdOk, sawDone;
      logic  rs, rc;
      logic [7:0] ra, rb;

      vecs[0] = '{1'b0, 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
      vecs[5] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[6] = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};

      total = 0;
      bad   = 0;
      lastSum = 8'h00;
      rst = 1'b1;
      start = 1'b0; sub = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
      start2 = 1'b0; sub2 = 1'b0; a2 = 2'b00; b2 = 2'b00; cin2 = 1'b0;
      step();
      step();
      rst = 1'b0;
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset done", 64'(done), 64'd0);
      checkOutput("reset sum", 64'(sum), 64'd0);
      checkOutput("reset cout", 64'(cout), 64'd0);
      checkOutput("reset overflow", 64'(overflow), 64'd0);
      checkOutput("reset w2 sum", 64'({busy2, done2, cout2, overflow2, sum2}), 64'd0);
      step();

      for (int i = 0; i < 7; i++) begin
         runAndCheck($sformatf("vec%0d", i), vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin,
                     vecs[i].sum, vecs[i].cout, vecs[i].ovf);
         step();
         checkOutput($sformatf("vec%0d done pulse", i), 64'(done), 64'd0);
         checkOutput($sformatf("vec%0d idle hold", i), 64'(sum), 64'(vecs[i].sum));
      end

      // Handshake: starts during RUN are ignored.
      sub = 1'b0; a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      a = 8'h77; b = 8'h77; cin = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      checkOutput("handshake done", 64'(done), 64'd1);
      checkOutput("handshake sum", 64'(sum), 64'h02);
      lastSum = 8'h02;
      runAndCheck("back-to-back", 1'b0, 8'h10, 8'h22, 1'b0, 8'h32, 1'b0, 1'b0);

      // Reset in the middle of an operation.
      step();
      sub = 1'b0; a = 8'hFF; b = 8'h01; cin = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkOutput("abort busy", 64'(busy), 64'd0);
      checkOutput("abort sum", 64'(sum), 64'd0);
      checkOutput("abort cout", 64'(cout), 64'd0);
      checkOutput("abort overflow", 64'(overflow), 64'd0);
      sawDone = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (done === 1'b1) sawDone = 1'b1;
         step();
      end
      checkOutput("abort no done", 64'(sawDone), 64'd0);
      lastSum = 8'h00;
      runAndCheck("after abort", 1'b0, 8'h21, 8'h12, 1'b1, 8'h34, 1'b0, 1'b0);

      // Random operations against the arithmetic model.
      for (int i = 0; i < 40; i++) begin
         rs = 1'($urandom);
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         r  = model(8, rs, longint'(ra), longint'(rb), rc);
         if ((i % 3) != 0) step();
         runAndCheck($sformatf("rand%0d", i), rs, ra, rb, rc, r.sum[7:0], r.cout, r.ovf);
      end

      // Exhaustive WIDTH=2.
      step();
      for (int s = 0; s < 2; s++) begin
         for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
               for (int c = 0; c < 2; c++) begin
                  if (s == 1 && c == 1) continue;
                  r = model(2, 1'(s), longint'(x), longint'(y), 1'(c));
                  applyStimulus2(1'(s), 2'(x), 2'(y), 1'(c), lat);
                  checkOutput($sformatf("w2 s%0d a%0d b%0d c%0d latency", s, x, y, c),
                              64'(lat), 64'd3);
                  checkOutput($sformatf("w2 s%0d a%0d b%0d c%0d result", s, x, y, c),
                              64'({overflow2, cout2, sum2}), 64'({r.ovf, r.cout, r.sum[1:0]}));
               end
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
